// File: rtl/uart_pkg.sv
// uart_pkg: receiver/transmitter shared state encoding and default frame constants
package uart_pkg;
    typedef enum logic [1:0] {IDLE, START, DATA, STOP} uart_state_t;
    localparam int OVERSAMPLE_DEF = 16;
    localparam int DATA_BITS_DEF = 8;
endpackage

// File: rtl/uart_rx_sync.sv
// uart_rx_sync: two-flop synchronizer for the async rx line, resets to the idle-high level
module uart_rx_sync (
    input  logic clk,
    input  logic rst,
    input  logic d,
    output logic q
);
    logic meta;
    always_ff @(posedge clk) begin
        if (rst) {q, meta} <= 2'b11;
        else {q, meta} <= {meta, d};
    end
endmodule

// File: rtl/uart_receiver.sv
// uart_receiver: oversampled 8N1 UART receive end with sticky ready, framing-error and overrun status
module uart_receiver
    import uart_pkg::*;
#(
    parameter int OVERSAMPLE = OVERSAMPLE_DEF,
    parameter int DATA_BITS = DATA_BITS_DEF
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 rx,
    input  logic                 enb,
    input  logic                 rdy_clr,
    output logic [DATA_BITS-1:0] data_out,
    output logic                 rdy,
    output logic                 busy,
    output logic                 frame_err,
    output logic                 overrun
);
    localparam int CW = $clog2(OVERSAMPLE);
    localparam int IW = $clog2(DATA_BITS);
    localparam logic [CW-1:0] HALF_END = CW'(OVERSAMPLE / 2 - 1);
    localparam logic [CW-1:0] BIT_END = CW'(OVERSAMPLE - 1);
    localparam logic [IW-1:0] IDX_END = IW'(DATA_BITS - 1);
    uart_state_t state, state_n;
    logic [CW-1:0] cnt, cnt_n;
    logic [IW-1:0] idx, idx_n;
    logic [DATA_BITS-1:0] shift, shift_n, data_n;
    logic rdy_n, ferr_n, ovr_n, rx_s;
    uart_rx_sync u_sync (.clk(clk), .rst(rst), .d(rx), .q(rx_s));
    assign busy = state != IDLE;
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
            cnt <= '0;
            idx <= '0;
            shift <= '0;
            data_out <= '0;
            rdy <= 1'b0;
            frame_err <= 1'b0;
            overrun <= 1'b0;
        end else begin
            state <= state_n;
            cnt <= cnt_n;
            idx <= idx_n;
            shift <= shift_n;
            data_out <= data_n;
            rdy <= rdy_n;
            frame_err <= ferr_n;
            overrun <= ovr_n;
        end
    end
    always_comb begin
        state_n = state;
        cnt_n = cnt;
        idx_n = idx;
        shift_n = shift;
        data_n = data_out;
        rdy_n = rdy & ~rdy_clr;
        ovr_n = overrun & ~rdy_clr;
        ferr_n = frame_err;
        if (enb) begin
            case (state)
                IDLE: begin
                    if (!rx_s) begin
                        state_n = START;
                        cnt_n = '0;
                    end
                end
                START: begin
                    cnt_n = cnt + 1'b1;
                    if (cnt == HALF_END) begin
                        state_n = rx_s ? IDLE : DATA;
                        cnt_n = '0;
                        idx_n = '0;
                    end
                end
                DATA: begin
                    cnt_n = cnt + 1'b1;
                    if (cnt == BIT_END) begin
                        shift_n[idx] = rx_s;
                        state_n = (idx == IDX_END) ? STOP : DATA;
                        idx_n = (idx == IDX_END) ? idx : idx + 1'b1;
                    end
                end
                STOP: begin
                    cnt_n = cnt + 1'b1;
                    // Leaving at stop centre leaves half a bit to catch the next start edge
                    if (cnt == BIT_END) begin
                        state_n = IDLE;
                        cnt_n = '0;
                        ferr_n = ~rx_s;
                        if (rx_s) begin
                            data_n = shift;
                            rdy_n = 1'b1;
                            ovr_n = (overrun | rdy) & ~rdy_clr;
                        end
                    end
                end
                default: state_n = IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_uart_receiver.sv
// tb_uart_receiver: scenario tasks with a byte scoreboard; enb every 4 clk, 64-clk bit periods
module tb_uart_receiver;
    localparam int BIT_CLK = 64;
    logic clk = 1'b0;
    logic rst, rx, enb, rdy_clr;
    logic [7:0] data_out;
    logic rdy, busy, frame_err, overrun;
    int checks = 0;
    int errors = 0;
    logic [7:0] exp_q[$];
    logic [7:0] exp, last_good;

    uart_receiver #(.OVERSAMPLE(16), .DATA_BITS(8)) dut (
        .clk(clk), .rst(rst), .rx(rx), .enb(enb), .rdy_clr(rdy_clr),
        .data_out(data_out), .rdy(rdy), .busy(busy), .frame_err(frame_err), .overrun(overrun)
    );

    always #5 clk = ~clk;

    initial begin : enb_gen
        int ph;
        ph = 0;
        enb = 1'b0;
        forever begin
            @(negedge clk);
            enb = (ph == 3);
            ph = (ph + 1) % 4;
        end
    end

    initial begin : watchdog
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    task automatic send_frame(input logic [7:0] d, input logic stop, input int slots);
        logic [9:0] bits;
        bits = {stop, d, 1'b0};
        for (int i = 0; i < slots; i++) begin
            rx = bits[i];
            repeat (BIT_CLK) @(negedge clk);
        end
    endtask

    task automatic idle(input int n);
        rx = 1'b1;
        repeat (n) @(negedge clk);
    endtask

    task automatic pulse_clr();
        rdy_clr = 1'b1;
        @(negedge clk);
        rdy_clr = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_reset();
        rst = 1'b1; rx = 1'b1; rdy_clr = 1'b0;
        repeat (4) @(negedge clk);
        checks++; if (data_out !== 8'h00) begin errors++; $display("FAIL reset_data got %h exp 00", data_out); end
        checks++; if (rdy !== 1'b0) begin errors++; $display("FAIL reset_rdy got %b exp 0", rdy); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy got %b exp 0", busy); end
        checks++; if (frame_err !== 1'b0) begin errors++; $display("FAIL reset_ferr got %b exp 0", frame_err); end
        checks++; if (overrun !== 1'b0) begin errors++; $display("FAIL reset_ovr got %b exp 0", overrun); end
        rst = 1'b0;
        idle(64);
    endtask

    task automatic test_good_byte();
        exp_q.push_back(8'hA5);
        send_frame(8'hA5, 1'b1, 10);
        idle(64);
        exp = exp_q.pop_front();
        last_good = exp;
        checks++; if (data_out !== exp) begin errors++; $display("FAIL good_data got %h exp %h", data_out, exp); end
        checks++; if (rdy !== 1'b1) begin errors++; $display("FAIL good_rdy got %b exp 1", rdy); end
        checks++; if (frame_err !== 1'b0) begin errors++; $display("FAIL good_ferr got %b exp 0", frame_err); end
        checks++; if (overrun !== 1'b0) begin errors++; $display("FAIL good_ovr got %b exp 0", overrun); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL good_busy got %b exp 0", busy); end
        pulse_clr();
        checks++; if (rdy !== 1'b0) begin errors++; $display("FAIL good_clr_rdy got %b exp 0", rdy); end
        checks++; if (data_out !== last_good) begin errors++; $display("FAIL good_clr_data got %h exp %h", data_out, last_good); end
    endtask

    task automatic test_glitch();
        rx = 1'b0;
        repeat (12) @(negedge clk);
        checks++; if (busy !== 1'b1) begin errors++; $display("FAIL glitch_start_busy got %b exp 1", busy); end
        repeat (8) @(negedge clk);
        idle(128);
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL glitch_busy got %b exp 0", busy); end
        checks++; if (rdy !== 1'b0) begin errors++; $display("FAIL glitch_rdy got %b exp 0", rdy); end
        checks++; if (frame_err !== 1'b0) begin errors++; $display("FAIL glitch_ferr got %b exp 0", frame_err); end
    endtask

    task automatic test_framing();
        send_frame(8'h3C, 1'b0, 10);
        idle(128);
        checks++; if (frame_err !== 1'b1) begin errors++; $display("FAIL frame_ferr got %b exp 1", frame_err); end
        checks++; if (rdy !== 1'b0) begin errors++; $display("FAIL frame_rdy got %b exp 0", rdy); end
        checks++; if (data_out !== last_good) begin errors++; $display("FAIL frame_data got %h exp %h", data_out, last_good); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL frame_busy got %b exp 0", busy); end
    endtask

    task automatic test_back_to_back();
        exp_q.push_back(8'h01);
        exp_q.push_back(8'hFE);
        send_frame(8'h01, 1'b1, 10);
        send_frame(8'hFE, 1'b1, 10);
        idle(64);
        exp = exp_q.pop_front();
        exp = exp_q.pop_front();
        checks++; if (data_out !== exp) begin errors++; $display("FAIL b2b_data got %h exp %h", data_out, exp); end
        checks++; if (rdy !== 1'b1) begin errors++; $display("FAIL b2b_rdy got %b exp 1", rdy); end
        checks++; if (overrun !== 1'b1) begin errors++; $display("FAIL b2b_ovr got %b exp 1", overrun); end
        checks++; if (frame_err !== 1'b0) begin errors++; $display("FAIL b2b_ferr got %b exp 0", frame_err); end
        pulse_clr();
        checks++; if (rdy !== 1'b0) begin errors++; $display("FAIL b2b_clr_rdy got %b exp 0", rdy); end
        checks++; if (overrun !== 1'b0) begin errors++; $display("FAIL b2b_clr_ovr got %b exp 0", overrun); end
    endtask

    task automatic test_clr_coincident();
        exp_q.push_back(8'h11);
        send_frame(8'h11, 1'b1, 10);
        idle(64);
        exp = exp_q.pop_front();
        checks++; if (data_out !== exp) begin errors++; $display("FAIL coin_first_data got %h exp %h", data_out, exp); end
        checks++; if (rdy !== 1'b1) begin errors++; $display("FAIL coin_first_rdy got %b exp 1", rdy); end
        exp_q.push_back(8'h22);
        fork
            send_frame(8'h22, 1'b1, 10);
            begin
                int n;
                logic [7:0] e;
                n = 0;
                while (busy !== 1'b1 && n < 100) begin
                    @(negedge clk);
                    n++;
                end
                checks++; if (busy !== 1'b1) begin errors++; $display("FAIL coin_detect got busy=%b after %0d clk exp 1", busy, n); end
                // stop centre is 152 enb ticks (608 clk) after the start-detect edge
                repeat (607) @(negedge clk);
                checks++; if (busy !== 1'b1) begin errors++; $display("FAIL coin_pre_busy got %b exp 1", busy); end
                rdy_clr = 1'b1;
                @(negedge clk);
                rdy_clr = 1'b0;
                e = exp_q.pop_front();
                checks++; if (busy !== 1'b0) begin errors++; $display("FAIL coin_busy got %b exp 0", busy); end
                checks++; if (data_out !== e) begin errors++; $display("FAIL coin_data got %h exp %h", data_out, e); end
                checks++; if (rdy !== 1'b1) begin errors++; $display("FAIL coin_rdy got %b exp 1", rdy); end
                checks++; if (overrun !== 1'b0) begin errors++; $display("FAIL coin_ovr got %b exp 0", overrun); end
            end
        join
        idle(64);
        checks++; if (overrun !== 1'b0) begin errors++; $display("FAIL coin_ovr_after got %b exp 0", overrun); end
    endtask

    task automatic test_mid_reset();
        send_frame(8'h55, 1'b1, 5);
        rx = 1'b1;
        repeat (32) @(negedge clk);
        rst = 1'b1;
        repeat (2) @(negedge clk);
        checks++; if (data_out !== 8'h00) begin errors++; $display("FAIL mrst_data got %h exp 00", data_out); end
        checks++; if (rdy !== 1'b0) begin errors++; $display("FAIL mrst_rdy got %b exp 0", rdy); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL mrst_busy got %b exp 0", busy); end
        checks++; if (frame_err !== 1'b0) begin errors++; $display("FAIL mrst_ferr got %b exp 0", frame_err); end
        checks++; if (overrun !== 1'b0) begin errors++; $display("FAIL mrst_ovr got %b exp 0", overrun); end
        rst = 1'b0;
        idle(128);
        exp_q.push_back(8'h55);
        send_frame(8'h55, 1'b1, 10);
        idle(64);
        exp = exp_q.pop_front();
        checks++; if (data_out !== exp) begin errors++; $display("FAIL mrst_next_data got %h exp %h", data_out, exp); end
        checks++; if (rdy !== 1'b1) begin errors++; $display("FAIL mrst_next_rdy got %b exp 1", rdy); end
        checks++; if (frame_err !== 1'b0) begin errors++; $display("FAIL mrst_next_ferr got %b exp 0", frame_err); end
    endtask

    initial begin
        rst = 1'b1;
        rx = 1'b1;
        rdy_clr = 1'b0;
        last_good = 8'h00;
        test_reset();
        test_good_byte();
        test_glitch();
        test_framing();
        test_back_to_back();
        test_clr_coincident();
        test_mid_reset();
        checks++; if (exp_q.size() != 0) begin errors++; $display("FAIL scoreboard_left got %0d exp 0", exp_q.size()); end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
